divider_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared 64-bit combinational `divider` (ports `a`, `div`, `r`, `quo`). It accepts divide requests from NREQ requesters and selects one at a time with a round-robin arbiter. It holds the selected operands stable in registers for a fixed multicycle settle window, then returns quotient, remainder and requester ID on one shared response port. Divide-by-zero is detected and bypassed; it never reaches the datapath result.

---
 rtl/divider_ctrl_pkg.sv | 10 +
 rtl/divider.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/divider_ctrl.sv | 145 ++++++++++++++
 tb/tb_divider_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/divider_ctrl_pkg.sv
// Shared types for the divider sequencing controller.
package divider_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/divider.sv
// Shared combinational unsigned divider; a zero divisor yields all-ones quotient, remainder = a.
module divider #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] quo
);

    always_comb begin
        if (div == '0) begin
            quo = '1;
            r   = a;
        end else begin
            quo = a / div;
            r   = a % div;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IdW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IdW-1:0]  grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/divider_ctrl.sv
// Arbitrates NREQ divide requesters onto one combinational divider with a fixed settle window.
module divider_ctrl
    import divider_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 64,
    parameter int DIV_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NREQ)-1:0]       resp_id,
    output logic [WIDTH-1:0]              resp_quo,
    output logic [WIDTH-1:0]              resp_rem,
    output logic                          resp_dbz,
    output logic                          busy
);

    localparam int IdW  = $clog2(NREQ);
    localparam int CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [WIDTH-1:0] DbzQuo = {WIDTH{1'b1}};

    state_e            state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [NREQ-1:0]   grant;
    logic [IdW-1:0]    grant_idx;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [WIDTH-1:0]  div_quo, div_rem;

    rr_arbiter #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Divider sees only the operand registers, so its inputs are stable across the window.
    divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .a   (op_a_q),
        .div (op_b_q),
        .r   (div_rem),
        .quo (div_quo)
    );

    assign sel_a = req_a[grant_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        id_d    = id_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    op_a_d = sel_a;
                    op_b_d = sel_b;
                    id_d   = grant_idx;
                    ptr_d  = IdW'((int'(grant_idx) + 1) % NREQ);
                    if (sel_b == '0) begin
                        quo_d   = DbzQuo;
                        rem_d   = sel_a;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CntW'(DIV_CYCLES - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    quo_d   = div_quo;
                    rem_d   = div_rem;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            id_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            id_q    <= id_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign req_ready  = (rst_n && state_q == StIdle) ? grant : '0;
    assign resp_valid = (state_q == StDone);
    assign resp_id    = id_q;
    assign resp_quo   = quo_q;
    assign resp_rem   = rem_q;
    assign resp_dbz   = dbz_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed self-checking bench for divider_ctrl (NREQ=4, WIDTH=64, DIV_CYCLES=4).
module tb_divider_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int DC    = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_id;
    logic [WIDTH-1:0]      resp_quo;
    logic [WIDTH-1:0]      resp_rem;
    logic                  resp_dbz;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    divider_ctrl #(
        .NREQ       (NREQ),
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_quo   (resp_quo),
        .resp_rem   (resp_rem),
        .resp_dbz   (resp_dbz),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request from requester id and check latency and response fields.
    task automatic do_req(input string tag, input int id, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, input logic [63:0] exp_quo,
                          input logic [63:0] exp_rem, input logic exp_dbz);
        logic seen;
        int   lat;
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[id] = 1'b1;
        @(negedge clk);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (req_ready[id]) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_ready"}, 64'(req_ready), 64'(onehot));
        if (!seen) return;
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) seen = 1'b1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_quo"}, resp_quo, exp_quo);
        check({tag, "_rem"}, resp_rem, exp_rem);
        check({tag, "_id"},  64'(resp_id), 64'(id));
        check({tag, "_dbz"}, 64'(resp_dbz), 64'(exp_dbz));
        @(negedge clk);
        check({tag, "_drop"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};

    initial begin
        int g;
        int r;
        int gi;
        logic [63:0] hq, hr;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_quo",   resp_quo, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("r0", 0, 64'd8, 64'd2, DC + 1, 64'd4, 64'd0, 1'b0);
        do_req("r2", 2, 64'd42398284, 64'd54389, DC + 1, 64'd779, 64'd29253, 1'b0);
        do_req("r1", 1, 64'd34224, 64'd789799, DC + 1, 64'd0, 64'd34224, 1'b0);
        do_req("dbz", 3, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);

        // Round robin with all requesters valid from reset.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 64'(100 + i);
            req_b[i*WIDTH +: WIDTH] = 64'(i + 1);
        end
        req_valid = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        g = 0;
        r = 0;
        for (int k = 0; k < 200 && r < 5; k++) begin
            #1;
            if (busy) begin
                check("rr_ready_busy", 64'(req_ready), 64'd0);
            end else if (g < 5) begin
                check("rr_onehot", 64'($countones(req_ready)), 64'd1);
                gi = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
                check("rr_grant", 64'(gi), 64'(exp_g[g]));
                g++;
            end
            if (resp_valid) begin
                check("rr_resp_id", 64'(resp_id), 64'(exp_g[r]));
                r++;
            end
            @(negedge clk);
        end
        check("rr_done", 64'(r), 64'd5);
        req_valid = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Backpressure: 17/5 from requester 1 held in DONE.
        resp_ready = 1'b0;
        req_a[1*WIDTH +: WIDTH] = 64'd17;
        req_b[1*WIDTH +: WIDTH] = 64'd5;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 40 && !resp_valid; k++) begin
            @(negedge clk);
            if (!busy) continue;
            req_valid[1] = 1'b0;
        end
        req_valid[1] = 1'b0;
        check("bp_valid", 64'(resp_valid), 64'd1);
        hq = 64'd3;
        hr = 64'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(resp_valid), 64'd1);
            check("bp_hold_quo", resp_quo, hq);
            check("bp_hold_rem", resp_rem, hr);
            check("bp_hold_id", 64'(resp_id), 64'd1);
            check("bp_hold_dbz", 64'(resp_dbz), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(resp_valid), 64'd0);

        // Reset mid-WAIT: 50/7 from requester 1 leaves ptr at 2 before the reset.
        req_a[1*WIDTH +: WIDTH] = 64'd50;
        req_b[1*WIDTH +: WIDTH] = 64'd7;
        req_a[3*WIDTH +: WIDTH] = 64'd9;
        req_b[3*WIDTH +: WIDTH] = 64'd3;
        req_valid = 4'b0010;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(negedge clk);
        check("wr_busy", 64'(busy), 64'd1);
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        check("wr_ready", 64'(req_ready), 64'd0);
        check("wr_outs", {resp_quo[31:0], resp_rem[27:0], resp_id, resp_valid, resp_dbz},
              64'd0);
        check("wr_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < DC + 3; k++) begin
            @(negedge clk);
            check("wr_no_resp", 64'({resp_valid, busy}), 64'd0);
        end
        req_valid = 4'b1010;
        #1;
        check("wr_lowest", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        for (int k = 0; k < 40 && !resp_valid; k++) @(negedge clk);
        check("wr_quo", resp_quo, 64'd7);
        check("wr_rem", resp_rem, 64'd1);
        check("wr_id", 64'(resp_id), 64'd1);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
